// File: rtl/af_register_pkg.sv
// Shared CPU definitions for the accumulator/flag register.
// Flag indices, sequencer state codes and register reset values.
package af_register_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PUSH_HI = 3'd1;
    localparam logic [2:0] ST_PUSH_LO = 3'd2;
    localparam logic [2:0] ST_POP_LO  = 3'd3;
    localparam logic [2:0] ST_POP_HI  = 3'd4;

    localparam logic [7:0] A_RESET = 8'h00;
    localparam logic [3:0] F_RESET = 4'h0;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

    function automatic logic [3:0] merge_flags(
        input logic [3:0] cur,
        input logic [3:0] nxt,
        input logic [3:0] mask
    );
        return (nxt & mask) | (cur & ~mask);
    endfunction

endpackage

// File: rtl/af_register_if.sv
// ALU commit, stack transfer and status bundle for af_register.
// master drives requests; slave is the register itself.
interface af_register_if;
    import af_register_pkg::*;

    logic       i_Alu_Valid;
    logic [7:0] i_Alu_A;
    logic       i_Alu_Write_A;
    logic [3:0] i_Alu_F;
    logic [3:0] i_Flag_Mask;
    logic       i_Push_Start;
    logic       i_Push_Ready;
    logic       o_Push_Valid;
    logic [7:0] o_Push_Data;
    logic       i_Pop_Start;
    logic       i_Pop_Valid;
    logic [7:0] i_Pop_Data;
    logic [7:0] o_A;
    logic [3:0] o_F;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Collision;

    modport master (
        output i_Alu_Valid, i_Alu_A, i_Alu_Write_A, i_Alu_F, i_Flag_Mask,
        output i_Push_Start, i_Push_Ready,
        output i_Pop_Start, i_Pop_Valid, i_Pop_Data,
        input  o_Push_Valid, o_Push_Data,
        input  o_A, o_F, o_Busy, o_Done, o_Collision
    );

    modport slave (
        input  i_Alu_Valid, i_Alu_A, i_Alu_Write_A, i_Alu_F, i_Flag_Mask,
        input  i_Push_Start, i_Push_Ready,
        input  i_Pop_Start, i_Pop_Valid, i_Pop_Data,
        output o_Push_Valid, o_Push_Data,
        output o_A, o_F, o_Busy, o_Done, o_Collision
    );

endinterface

// File: rtl/af_register.sv
// Accumulator and flag register with masked ALU commit and a
// two-byte PUSH AF / POP AF sequencer.
module af_register
    import af_register_pkg::*;
(
    input  logic          i_Clk,
    input  logic          i_Reset,
    af_register_if.slave  bus
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] a_reg;
    logic [3:0] f_reg;
    logic [3:0] f_stage;
    logic       done_reg;
    logic       coll_reg;

    logic       idle;
    logic       alu_commit;
    logic       push_take;
    logic       pop_take;
    logic       collide;
    logic       finish;

    assign idle = (state == ST_IDLE);

    // ALU commit and push start may share a cycle; push wins over pop.
    assign alu_commit = idle && bus.i_Alu_Valid;
    assign push_take  = idle && bus.i_Push_Start;
    assign pop_take   = idle && bus.i_Pop_Start && !bus.i_Push_Start;

    always_comb begin
        collide = 1'b0;
        if (idle) begin
            collide = bus.i_Push_Start && bus.i_Pop_Start;
        end else begin
            collide = bus.i_Alu_Valid || bus.i_Push_Start ||
                      bus.i_Pop_Start;
        end
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (push_take) begin
                    state_nxt = ST_PUSH_HI;
                end else if (pop_take) begin
                    state_nxt = ST_POP_LO;
                end
            end
            ST_PUSH_HI: begin
                if (bus.i_Push_Ready) begin
                    state_nxt = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                if (bus.i_Push_Ready) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            ST_POP_LO: begin
                if (bus.i_Pop_Valid) begin
                    state_nxt = ST_POP_HI;
                end
            end
            ST_POP_HI: begin
                if (bus.i_Pop_Valid) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            a_reg    <= A_RESET;
            f_reg    <= F_RESET;
            f_stage  <= 4'h0;
            done_reg <= 1'b0;
            coll_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_reg <= finish;
            coll_reg <= collide;
            if (alu_commit) begin
                f_reg <= merge_flags(f_reg, bus.i_Alu_F, bus.i_Flag_Mask);
                if (bus.i_Alu_Write_A) begin
                    a_reg <= bus.i_Alu_A;
                end
            end
            if (state == ST_POP_LO && bus.i_Pop_Valid) begin
                f_stage <= bus.i_Pop_Data[7:4];
            end
            // Both halves land together so a partial POP is never visible.
            if (state == ST_POP_HI && bus.i_Pop_Valid) begin
                a_reg <= bus.i_Pop_Data;
                f_reg <= f_stage;
            end
        end
    end

    always_comb begin
        bus.o_Push_Valid = 1'b0;
        bus.o_Push_Data  = 8'h00;
        case (state)
            ST_PUSH_HI: begin
                bus.o_Push_Valid = 1'b1;
                bus.o_Push_Data  = a_reg;
            end
            ST_PUSH_LO: begin
                bus.o_Push_Valid = 1'b1;
                bus.o_Push_Data  = {f_reg, 4'h0};
            end
            default: begin
                bus.o_Push_Valid = 1'b0;
                bus.o_Push_Data  = 8'h00;
            end
        endcase
    end

    assign bus.o_A         = a_reg;
    assign bus.o_F         = f_reg;
    assign bus.o_Busy      = !idle;
    assign bus.o_Done      = done_reg;
    assign bus.o_Collision = coll_reg;

endmodule

// File: tb/tb_af_register.sv
// Directed bench for af_register with a stack-byte scoreboard.
// Expected values come from a small A/F model kept in the bench.
module tb_af_register;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [7:0] m_a;
    logic [3:0] m_f;
    logic [7:0] push_q[$];
    logic [11:0] pop_q[$];
    logic [7:0] exp_byte;
    logic [11:0] exp_af;

    af_register_if bus();

    af_register u_dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Alu_Valid   = 1'b0;
        bus.i_Alu_A       = 8'h00;
        bus.i_Alu_Write_A = 1'b0;
        bus.i_Alu_F       = 4'h0;
        bus.i_Flag_Mask   = 4'h0;
        bus.i_Push_Start  = 1'b0;
        bus.i_Push_Ready  = 1'b0;
        bus.i_Pop_Start   = 1'b0;
        bus.i_Pop_Valid   = 1'b0;
        bus.i_Pop_Data    = 8'h00;
    endtask

    task automatic alu(input logic [7:0] a, input logic [3:0] f,
                       input logic [3:0] mask, input logic wa);
        bus.i_Alu_Valid   = 1'b1;
        bus.i_Alu_A       = a;
        bus.i_Alu_F       = f;
        bus.i_Flag_Mask   = mask;
        bus.i_Alu_Write_A = wa;
        tick();
        bus.i_Alu_Valid   = 1'b0;
        m_f = (f & mask) | (m_f & ~mask);
        if (wa) m_a = a;
    endtask

    task automatic chk_af(input string tag);
        chk({tag, "_a"}, {8'h00, bus.o_A}, {8'h00, m_a});
        chk({tag, "_f"}, {12'h000, bus.o_F}, {12'h000, m_f});
    endtask

    // Drains the push scoreboard with ready held high.
    task automatic drain_push();
        bus.i_Push_Ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("push_valid", {15'h0, bus.o_Push_Valid}, 16'h0001);
            exp_byte = push_q.pop_front();
            chk("push_data", {8'h00, bus.o_Push_Data}, {8'h00, exp_byte});
            tick();
        end
        bus.i_Push_Ready = 1'b0;
        chk("push_done", {15'h0, bus.o_Done}, 16'h0001);
        chk("push_busy_end", {15'h0, bus.o_Busy}, 16'h0000);
    endtask

    task automatic start_push();
        push_q.push_back(m_a);
        push_q.push_back({m_f, 4'h0});
    endtask

    // Sends two stack bytes; model updates only when the POP finishes.
    task automatic pop_bytes(input logic [7:0] lo, input logic [7:0] hi);
        pop_q.push_back({hi, lo[7:4]});
        bus.i_Pop_Valid = 1'b1;
        bus.i_Pop_Data  = lo;
        tick();
        chk_af("pop_mid");
        chk("pop_mid_busy", {15'h0, bus.o_Busy}, 16'h0001);
        bus.i_Pop_Data  = hi;
        tick();
        bus.i_Pop_Valid = 1'b0;
        exp_af = pop_q.pop_front();
        m_a = exp_af[11:4];
        m_f = exp_af[3:0];
        chk_af("pop_end");
        chk("pop_done", {15'h0, bus.o_Done}, 16'h0001);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_a = 8'h00;
        m_f = 4'h0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_af("reset");
        chk("reset_busy", {15'h0, bus.o_Busy}, 16'h0000);
        chk("reset_pvalid", {15'h0, bus.o_Push_Valid}, 16'h0000);
        chk("reset_pdata", {8'h00, bus.o_Push_Data}, 16'h0000);
        chk("reset_done", {15'h0, bus.o_Done}, 16'h0000);
        chk("reset_coll", {15'h0, bus.o_Collision}, 16'h0000);
        rst = 1'b0;
        tick();

        alu(8'h3C, 4'hF, 4'hF, 1'b1);
        chk_af("alu_full");
        alu(8'h77, 4'h0, 4'b1110, 1'b0);
        chk_af("alu_mask");
        chk("alu_mask_f1", {12'h0, bus.o_F}, 16'h0001);

        alu(8'h12, 4'hA, 4'hF, 1'b1);
        chk_af("alu_set");

        // Strays outside their states must be ignored.
        bus.i_Pop_Valid  = 1'b1;
        bus.i_Pop_Data   = 8'hFF;
        bus.i_Push_Ready = 1'b1;
        tick();
        bus.i_Pop_Valid  = 1'b0;
        bus.i_Push_Ready = 1'b0;
        chk_af("stray");
        chk("stray_busy", {15'h0, bus.o_Busy}, 16'h0000);

        bus.i_Push_Start = 1'b1;
        start_push();
        tick();
        bus.i_Push_Start = 1'b0;
        chk("push_busy", {15'h0, bus.o_Busy}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", {8'h00, bus.o_Push_Data}, {8'h00, push_q[0]});
            chk_af("stall");
            tick();
        end
        drain_push();
        tick();
        chk("done_once", {15'h0, bus.o_Done}, 16'h0000);

        bus.i_Pop_Start = 1'b1;
        tick();
        bus.i_Pop_Start = 1'b0;
        pop_bytes(8'h5F, 8'hC3);
        tick();

        // ALU commit in POP_HI is dropped.
        bus.i_Pop_Start = 1'b1;
        tick();
        bus.i_Pop_Start = 1'b0;
        bus.i_Pop_Valid = 1'b1;
        bus.i_Pop_Data  = 8'h4E;
        tick();
        bus.i_Pop_Valid = 1'b0;
        bus.i_Alu_Valid = 1'b1;
        bus.i_Alu_A     = 8'hFF;
        bus.i_Alu_F     = 4'hF;
        bus.i_Flag_Mask = 4'hF;
        bus.i_Alu_Write_A = 1'b1;
        tick();
        bus.i_Alu_Valid = 1'b0;
        chk("coll_alu", {15'h0, bus.o_Collision}, 16'h0001);
        chk_af("coll_alu");
        tick();
        chk("coll_pulse", {15'h0, bus.o_Collision}, 16'h0000);
        bus.i_Pop_Valid = 1'b1;
        bus.i_Pop_Data  = 8'h99;
        tick();
        bus.i_Pop_Valid = 1'b0;
        m_a = 8'h99;
        m_f = 4'h4;
        chk_af("pop_after_coll");

        bus.i_Push_Start = 1'b1;
        bus.i_Pop_Start  = 1'b1;
        start_push();
        tick();
        bus.i_Push_Start = 1'b0;
        bus.i_Pop_Start  = 1'b0;
        chk("coll_both", {15'h0, bus.o_Collision}, 16'h0001);
        chk_af("coll_both");
        drain_push();
        tick();

        // Asynchronous reset in POP_HI.
        bus.i_Pop_Start = 1'b1;
        tick();
        bus.i_Pop_Start = 1'b0;
        bus.i_Pop_Valid = 1'b1;
        bus.i_Pop_Data  = 8'h7B;
        tick();
        bus.i_Pop_Valid = 1'b0;
        rst = 1'b1;
        #1;
        m_a = 8'h00;
        m_f = 4'h0;
        chk_af("rst_mid");
        chk("rst_mid_busy", {15'h0, bus.o_Busy}, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        bus.i_Pop_Start = 1'b1;
        tick();
        bus.i_Pop_Start = 1'b0;
        pop_bytes(8'h2A, 8'h81);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
